uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 108, meaning clock cycles per serial bit; legal values are integers >= 4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning receive buffer entries; legal values are powers of two, 2..16.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port resetActiveHigh, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port uartReceive, input, 1 bit: asynchronous serial line, 8N1, idle high, LSB first.
REQ-006 SHALL have port rxPop, input, 1 bit: pops the FIFO head this cycle.
REQ-007 SHALL have port errorClear, input, 1 bit: clears the sticky error flags.
REQ-008 SHALL have port rxData, output, 8 bits: the FIFO head byte; valid only while rxValid=1.
REQ-009 SHALL have port rxValid, output, 1 bit: FIFO not empty.
REQ-010 SHALL have port rxCount, output, $clog2(FIFO_DEPTH)+1 bits: FIFO occupancy.
REQ-011 SHALL have port rxByteDone, output, 1 bit: one-cycle pulse when a byte is pushed into the FIFO.
REQ-012 SHALL have port framingError, output, 1 bit: sticky flag set when the stop bit is sampled low.
REQ-013 SHALL have port overrunError, output, 1 bit: sticky flag set when a byte is dropped because the FIFO is full.

Function
REQ-014 SHALL pass uartReceive through a 2-flop synchronizer; all logic uses only the synchronized value rxSync.
REQ-015 SHALL implement receiver states IDLE, START, DATA and STOP, with one bit counter (0..CLKS_PER_BIT-1) and one bit index (0..7).
REQ-016 SHALL, in IDLE, move to START with the counter cleared on the first cycle rxSync=0 (cycle t0).
- In START, the start bit is sampled when the counter reaches CLKS_PER_BIT/2-1 (integer division).
REQ-017 SHALL, at the START sample, go to DATA with the counter cleared if rxSync=0, else return to IDLE.
- Returning to IDLE here is glitch rejection: no push, no flag change.
REQ-018 SHALL, in DATA, sample rxSync into shift bit[index] when the counter reaches CLKS_PER_BIT-1.
- At each sample the counter clears and the index increments.
- After bit 7 the state goes to STOP.
REQ-019 SHALL, in STOP, sample rxSync when the counter reaches CLKS_PER_BIT-1, then return to IDLE on the next cycle.
REQ-020 SHALL, if the stop sample is 1, push the assembled byte and pulse rxByteDone on the cycle after the sample.
REQ-021 SHALL, if the stop sample is 0, discard the byte and set framingError.
- IDLE then waits for the next falling level; a line held low is not re-armed until rxSync returns high.
REQ-022 SHALL make the stop sample occur at t0 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (+/-1).
REQ-023 SHALL make a pushed byte visible on rxData/rxValid on the cycle after the push.
REQ-024 SHALL act on rxPop only when rxValid=1; pop on empty is ignored with no underflow and no flag.
REQ-025 SHALL, on push and pop in the same cycle, perform both.
- Occupancy is unchanged.
- No overrun, even when the FIFO is full.
REQ-026 SHALL, on push while full without pop, drop the new byte, keep the FIFO contents, set overrunError and not pulse rxByteDone.
REQ-027 SHALL wrap the read and write pointers modulo FIFO_DEPTH.
- rxCount is FIFO_DEPTH when full and 0 when empty.
REQ-028 SHALL clear both sticky flags on errorClear; a flag set event in the same cycle wins.
REQ-029 SHALL keep receiving during FIFO reads; rxPop never stalls the receiver.

Reset
REQ-030 SHALL, on reset, force the state to IDLE and clear the counter, bit index, pointers and synchronizer.
- Synchronizer flops reset to 1.
- rxValid=0, rxCount=0, rxByteDone=0, framingError=0, overrunError=0, rxData=0.
REQ-031 SHALL, on reset asserted mid-frame, abort the frame with no push and no flags.
- Reception restarts only on a falling level seen after reset is released.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-032 SHALL cover: send 0xA5 8N1 -> one rxByteDone pulse, rxData=0xA5, rxValid=1, rxCount=1; rxPop -> rxValid=0.
REQ-033 SHALL cover: 4-cycle low glitch on idle line -> state returns to IDLE, rxCount=0, no flags.
REQ-034 SHALL cover: send 0x3C with the stop bit held low -> framingError=1, rxCount=0; errorClear -> framingError=0.
REQ-035 SHALL cover: send 0x01..0x05 with no pops -> rxCount=4, overrunError=1; pops yield 0x01,0x02,0x03,0x04.
REQ-036 SHALL cover: FIFO full, rxPop on the exact push cycle of 0x77 -> rxCount stays 4, overrunError=0, 0x77 at the tail.
REQ-037 SHALL cover: reset asserted during DATA bit 3 of 0xFF -> after release rxCount=0, no flags; next frame 0x5A received intact.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a small receive FIFO and sticky error flags.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | line idle; wait for rx_sync low (only once re-armed high)
// S_START | count to mid start bit, confirm low or reject as glitch
// S_DATA  | sample 8 data bits LSB first, one per CLKS_PER_BIT
// S_STOP  | sample stop bit; high -> push byte, low -> framing error
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 108,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clock,
  input  logic                          resetActiveHigh,
  input  logic                          uartReceive,
  input  logic                          rxPop,
  input  logic                          errorClear,
  output logic [7:0]                    rxData,
  output logic                          rxValid,
  output logic [$clog2(FIFO_DEPTH):0]   rxCount,
  output logic                          rxByteDone,
  output logic                          framingError,
  output logic                          overrunError
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [1:0]       sync_q, sync_d;
  logic             rx_sync;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             armed_q, armed_d;
  logic             push_q, push_d;
  logic             frame_err_set;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             framing_q, framing_d;
  logic             overrun_q, overrun_d;

  logic             fifo_full;
  logic             pop_fire;
  logic             push_fire;
  logic             overrun_set;

  assign rx_sync = sync_q[1];

  // Two-flop synchronizer input for the asynchronous serial line.
  always_comb begin
    sync_d = {sync_q[0], uartReceive};
  end

  // Receiver next-state: bit timing, shift assembly and stop-bit decision.
  // armed_q keeps a line that stays low after a bad stop bit (or across
  // reset) from being mistaken for a new start bit.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    armed_d       = armed_q;
    push_d        = 1'b0;
    frame_err_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (rx_sync) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_sync ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_sync;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rx_sync) begin
            push_d = 1'b1;
          end else begin
            frame_err_set = 1'b1;
            armed_d       = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping; a pop in the push cycle frees the slot so a full
  // FIFO still accepts the byte without overrun.
  always_comb begin
    fifo_full   = (count_q == CNT_FULL);
    pop_fire    = rxPop && (count_q != '0);
    push_fire   = push_q && (!fifo_full || pop_fire);
    overrun_set = push_q && fifo_full && !pop_fire;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push_fire) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_fire) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_fire, pop_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Sticky error flags; a set event beats a clear in the same cycle.
  always_comb begin
    framing_d = framing_q;
    overrun_d = overrun_q;
    if (errorClear) begin
      framing_d = 1'b0;
      overrun_d = 1'b0;
    end
    if (frame_err_set) framing_d = 1'b1;
    if (overrun_set)   overrun_d = 1'b1;
  end

  // State register for synchronizer, receiver, FIFO and flags.
  always_ff @(posedge clock) begin
    if (resetActiveHigh) begin
      sync_q    <= 2'b11;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      armed_q   <= 1'b0;
      push_q    <= 1'b0;
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      framing_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      armed_q   <= armed_d;
      push_q    <= push_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      framing_q <= framing_d;
      overrun_q <= overrun_d;
    end
  end

  assign rxValid      = (count_q != '0);
  assign rxData       = rxValid ? mem_q[rd_ptr_q] : 8'h00;
  assign rxCount      = count_q;
  assign rxByteDone   = push_fire;
  assign framingError = framing_q;
  assign overrunError = overrun_q;

endmodule
